// File: rtl/sft_pkg.sv
// Shared constants for the pipelined right barrel shifter.
package sft_pkg;

    localparam int unsigned D_WIDTH   = 16;
    localparam int unsigned SEL_WIDTH = 4;
    localparam int unsigned N_STAGE   = 4;

    // Shift amount per stage, MSB of sel first.
    localparam int unsigned STAGE_SHAMT [N_STAGE] = '{8, 4, 2, 1};

endpackage

// File: rtl/sft_r_stage.sv
// One registered stage of the right shifter: conditional shift by SHAMT with
// fill and sticky update, plus its valid bit and ready computation.
module sft_r_stage
    import sft_pkg::*;
#(
    parameter int unsigned SHAMT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   in_data,
    input  logic [SEL_WIDTH-1:0] in_sel,
    input  logic                 in_arith,
    input  logic                 in_fill,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_WIDTH-1:0]   out_data,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic                 out_arith,
    output logic                 out_fill,
    output logic                 out_sticky
);

    localparam int unsigned BIT = $clog2(SHAMT);

    logic [D_WIDTH-1:0]   data_d;
    logic [SEL_WIDTH-1:0] sel_d;
    logic                 sticky_d;

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        data_d   = in_data;
        sticky_d = in_sticky;
        sel_d    = in_sel;
        // Consumed bit is cleared so later stages only see what remains.
        sel_d[BIT] = 1'b0;
        if (in_sel[BIT]) begin
            data_d   = {{SHAMT{in_fill}}, in_data[D_WIDTH-1:SHAMT]};
            sticky_d = in_sticky | (|in_data[SHAMT-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            out_arith  <= 1'b0;
            out_fill   <= 1'b0;
            out_sticky <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data   <= data_d;
                out_sel    <= sel_d;
                out_arith  <= in_arith;
                out_fill   <= in_fill;
                out_sticky <= sticky_d;
            end
        end
    end

endmodule

// File: rtl/sft_r_pipe.sv
// Four-stage pipelined 16-bit right barrel shifter (8, 4, 2, 1) with
// logical/arithmetic fill, sticky bit and full valid/ready backpressure.
module sft_r_pipe
    import sft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [D_WIDTH-1:0]   x,
    input  logic [SEL_WIDTH-1:0] sel,
    input  logic                 arith,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [D_WIDTH-1:0]   y,
    output logic                 sticky
);

    // Index 0 is the pipeline input, index N_STAGE the output.
    logic                 v_c   [N_STAGE+1];
    logic                 rdy_c [N_STAGE+1];
    logic [D_WIDTH-1:0]   d_c   [N_STAGE+1];
    logic [SEL_WIDTH-1:0] s_c   [N_STAGE+1];
    logic                 a_c   [N_STAGE+1];
    logic                 f_c   [N_STAGE+1];
    logic                 st_c  [N_STAGE+1];

    assign v_c[0]  = in_valid;
    assign d_c[0]  = x;
    assign s_c[0]  = sel;
    assign a_c[0]  = arith;
    assign f_c[0]  = arith & x[D_WIDTH-1];
    assign st_c[0] = 1'b0;

    assign rdy_c[N_STAGE] = out_ready;
    assign in_ready       = rdy_c[0];

    genvar k;
    generate
        for (k = 0; k < N_STAGE; k++) begin : g_stage
            sft_r_stage #(
                .SHAMT(STAGE_SHAMT[k])
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (v_c[k]),
                .in_ready  (rdy_c[k]),
                .in_data   (d_c[k]),
                .in_sel    (s_c[k]),
                .in_arith  (a_c[k]),
                .in_fill   (f_c[k]),
                .in_sticky (st_c[k]),
                .out_valid (v_c[k+1]),
                .out_ready (rdy_c[k+1]),
                .out_data  (d_c[k+1]),
                .out_sel   (s_c[k+1]),
                .out_arith (a_c[k+1]),
                .out_fill  (f_c[k+1]),
                .out_sticky(st_c[k+1])
            );
        end
    endgenerate

    assign out_valid = v_c[N_STAGE];
    assign y         = d_c[N_STAGE];
    assign sticky    = st_c[N_STAGE];

endmodule

// File: doc/sft_r_pipe.md
# sft_r_pipe

Pipelined 16-bit right barrel shifter with valid/ready handshaking, the counterpart of the combinational low-fan-in left shifter in the perceptron datapath. It undoes the left normalisation after accumulation, shifting products/sums back into fixed-point range. It supports logical or arithmetic fill and reports a sticky bit (OR of all discarded bits) for downstream rounding. The block has four shift stages (8, 4, 2, 1), each registered, with full backpressure.

## Interface
- D_WIDTH, 16, data width; fixed at 16 for this block.
- SEL_WIDTH, 4, shift-amount width, equal to log2(D_WIDTH).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- x  in  D_WIDTH  input data.
- sel  in  SEL_WIDTH  unsigned right-shift amount, 0..15.
- arith  in  1  1 = sign fill (copies of x[15]); 0 = zero fill.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the beat.
- y  out  D_WIDTH  shifted data.
- sticky  out  1  OR of every bit shifted out of the LSB side.

## Operation
- A beat transfers on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
- Stage 1 shifts right by 8 if sel[3] is set. Stage 2 shifts by 4 if sel[2], stage 3 by 2 if sel[1], stage 4 by 1 if sel[0].
  - Each stage registers data, the remaining sel bits, arith, the fill bit, the sticky bit and a valid bit.
- Fill bit:
  - Captured at stage 1 as arith & x[15].
  - Vacated MSBs are filled with it in every stage.
- Sticky:
  - Stage 1 starts from 0.
  - Each stage ORs in the bits it drops: the low 8, 4, 2 or 1 bits when that stage's sel bit is set.
- Stage k advances when ready[k] = !valid[k] || ready[k+1], where ready[5] = out_ready and in_ready = ready[1].
  - This ready chain is combinational, back to front.
  - A bubble is absorbed in the same cycle it is exposed.
- Pipeline capacity is 4 beats.
  - With out_ready held low, exactly 4 beats are accepted, then in_ready deasserts.
- Order is strictly FIFO. No beat is dropped or duplicated.
- sel = 0 passes x unchanged with sticky = 0.
- sel = 15 with arith = 1 yields all x[15].
- No width growth. y is always D_WIDTH bits.
- No state machine beyond the per-stage valid bits; each stage is either empty or full.

## Timing
- Latency: 4 cycles from input acceptance to out_valid, with an unstalled pipeline.
- Throughput: 1 beat/cycle while out_ready = 1.
- Stall rule: while out_valid && !out_ready, y, sticky and out_valid hold stable until the transfer.
- Simultaneous accept and drain in the same stage is allowed; a full pipeline with out_ready = 1 still accepts every cycle.
- Reset values: all valid bits 0, out_valid 0, y 0, sticky 0; in_ready reads 1 while rst is high.
- Reset takes effect asynchronously. In-flight beats are discarded with no partial output.
- The first beat may be accepted on the first rising edge after rst deasserts.
- in_valid may be high during reset; the beat is not accepted.

## Structure
- Shared package sft_pkg holds:
  - D_WIDTH and SEL_WIDTH;
  - N_STAGE = 4;
  - the per-stage shift-amount constants 8, 4, 2, 1.
- Sub-module sft_r_stage:
  - parameter SHAMT;
  - one conditional right shift with fill and sticky update, plus its register, valid bit and ready computation.
- The top instantiates sft_r_stage four times with SHAMT = 8, 4, 2, 1 and chains the sel bits MSB first.

## Test plan
- x=16'h8001, sel=1, arith=0 -> after 4 cycles y=16'h4000, sticky=1.
- x=16'h8000, sel=15, arith=1 -> y=16'hFFFF, sticky=0; same with arith=0 -> y=16'h0001, sticky=0.
- x=16'h00F0, sel=4 -> y=16'h000F, sticky=0; sel=5 -> y=16'h0007, sticky=1; x=16'hA5A5, sel=0 -> y=16'hA5A5, sticky=0.
- Stream of 8 beats (x = 1..8, sel=0) with out_ready low for the first 10 cycles:
  - in_ready drops after 4 accepted beats;
  - outputs then arrive in order 1..8 with y stable during the stall;
  - no loss or duplication.
- Continuous streaming with out_ready = 1 -> one result per cycle, matching a reference model for all 16 sel values × both arith values on random x.
- rst pulsed with 3 beats in flight -> out_valid falls to 0 at once, in_ready=1, and after release the next input emerges 4 cycles later with no stale beats.
